// File: rtl/logic_gate_unit_if.sv
// rtl/logic_gate_unit_if.sv - operand/result handshake bundle for logic_gate_unit
interface logic_gate_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_parity, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_parity, op_count
  );
endinterface

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise gate unit with accumulator and output handshake
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_gate_unit_if.slave   bus
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_zero;
  logic             r_parity;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_y;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;

  assign w_a        = bus.in_acc ? r_acc : bus.in_a;
  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_valid && bus.out_ready;

  always_comb begin
    w_y = '0;
    case (bus.in_op)
      3'd0:    w_y = w_a & bus.in_b;
      3'd1:    w_y = w_a | bus.in_b;
      3'd2:    w_y = ~w_a;
      3'd3:    w_y = ~(w_a & bus.in_b);
      3'd4:    w_y = ~(w_a | bus.in_b);
      3'd5:    w_y = w_a ^ bus.in_b;
      3'd6:    w_y = ~(w_a ^ bus.in_b);
      default: w_y = w_a;
    endcase
  end

  // A new accept overrides the drain so out_valid stays high at full throughput
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_y      <= w_y;
        r_acc    <= w_y;
        r_zero   <= ~|w_y;
        r_parity <= ^w_y;
        r_valid  <= 1'b1;
      end else if (w_drain) begin
        r_valid  <= 1'b0;
      end
      if (w_drain && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_valid;
  assign bus.out_y      = r_y;
  assign bus.out_zero   = r_zero;
  assign bus.out_parity = r_parity;
  assign bus.op_count   = r_cnt;

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
Parametrised, registered successor to the two-input behavioural gate model. Applies one of eight bitwise gate operations to WIDTH-bit operands and returns the result through a valid/ready output stage. An accumulate mode chains results, and the block keeps status flags and a transaction counter. It sits as a reusable datapath primitive between streaming producers and consumers.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 16, width of the completed-transaction counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers an operation
in_ready  output  1  block can accept this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  opcode
in_acc  input  1  1 = use accumulator in place of in_a
out_valid  output  1  result held on out_y
out_ready  input  1  consumer accepts the result
out_y  output  WIDTH  registered result
out_zero  output  1  out_y == 0
out_parity  output  1  XOR-reduction of out_y
op_count  output  CNT_W  completed output handshakes, saturating

Behaviour:
- Interface: single clock clk; rst_n is asynchronous and active-low.
- Reset (asynchronous, rst_n=0) clears all state:
  - out_valid=0, out_y=0, out_zero=1, out_parity=0.
  - Accumulator acc_q=0, op_count=0.
  - Any pending result is discarded. No output handshake completes while rst_n=0.
- Opcode map (A = in_acc ? acc_q : in_a; B = in_b):
  - 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS A.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - On accept: out_y, out_zero and out_parity load the new result at that clock edge; out_valid=1 the next cycle. Latency is 1 cycle.
  - Stall (out_valid=1, out_ready=0): out_y and the flags hold stable and in_ready=0.
  - Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the old result completes and the new result loads the same edge, so out_valid stays 1. This gives full throughput of one operation per cycle.
  - Drain with no accept: out_valid -> 0; out_y and the flags keep their last values.
- Accumulator: acc_q loads the computed result on every accept, regardless of in_acc. in_acc=1 on the first operation after reset uses acc_q=0.
- out_zero and out_parity are registered with out_y and describe the value currently on out_y.
- op_count:
  - Increments by 1 on each output handshake (out_valid && out_ready).
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- All arithmetic is bitwise at WIDTH bits; no carries and no width growth.
- Inputs are sampled only on accept. Changes to in_* while in_ready=0 have no effect.

Test Plan:
1. Opcode sweep, WIDTH=8, in_a=F0, in_b=3C, ops 0..7, out_ready=1 -> out_y = 30, FC, 0F, CF, 03, CC, 33, F0, each one cycle after its accept; op_count=8.
2. Accumulate chain:
   - PASS in_a=AA -> AA.
   - in_acc=1 XOR in_b=FF -> 55.
   - in_acc=1 XOR in_b=FF -> AA.
   - in_acc=1 AND in_b=0F -> 0A.
3. Backpressure: accept AND 0F/F0 -> 00, then hold out_ready=0 for 5 cycles with in_valid=1 and OR F0/0F presented:
   - in_ready=0; out_y=00, out_zero=1 stable.
   - Raise out_ready -> 00 completes and FF loads the same edge; the next cycle out_y=FF, out_zero=0, out_parity=0.
4. Back-to-back throughput: 16 consecutive accepts with out_ready=1 -> in_ready=1 every cycle, 16 results in order, op_count=16.
5. Saturation, CNT_W=2: 5 handshakes -> op_count 1, 2, 3, 3, 3.
6. Reset mid-operation: result pending with out_ready=0, assert rst_n=0 between clock edges -> outputs immediately out_valid=0, out_y=00, out_zero=1, op_count=0. After release, in_acc=1 PASS -> 00.
